// File: rtl/edit_field_ctrl_pkg.sv
// Shared definitions for the clock-overlay edit controller: FSM states,
// field indices, per-field value ranges and the RTC register map.
package edit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT_REQ,
    COMMIT_WAIT
  } state_t;

  localparam int NUM_FIELDS = 9;

  localparam logic [3:0] FLD_DAY   = 4'd0;
  localparam logic [3:0] FLD_MONTH = 4'd1;
  localparam logic [3:0] FLD_YEAR  = 4'd2;
  localparam logic [3:0] FLD_HOUR  = 4'd3;
  localparam logic [3:0] FLD_MIN   = 4'd4;
  localparam logic [3:0] FLD_SEC   = 4'd5;
  localparam logic [3:0] FLD_THOUR = 4'd6;
  localparam logic [3:0] FLD_TMIN  = 4'd7;
  localparam logic [3:0] FLD_TSEC  = 4'd8;

  // Tables are packed with field 0 in the least significant slot.
  localparam logic [NUM_FIELDS-1:0][6:0] FIELD_MIN =
    {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd1, 7'd1};
  localparam logic [NUM_FIELDS-1:0][6:0] FIELD_MAX =
    {7'd59, 7'd59, 7'd23, 7'd59, 7'd59, 7'd23, 7'd99, 7'd12, 7'd31};
  localparam logic [NUM_FIELDS-1:0][7:0] RTC_ADDR =
    {8'h41, 8'h42, 8'h43, 8'h21, 8'h22, 8'h23, 8'h26, 8'h25, 8'h24};

  function automatic logic [6:0] field_inc(input logic [3:0] idx, input logic [6:0] v);
    return (v >= FIELD_MAX[idx]) ? FIELD_MIN[idx] : v + 7'd1;
  endfunction

  function automatic logic [6:0] field_dec(input logic [3:0] idx, input logic [6:0] v);
    return (v <= FIELD_MIN[idx]) ? FIELD_MAX[idx] : v - 7'd1;
  endfunction

endpackage

// File: rtl/edit_field_ctrl_bin2bcd.sv
// Combinational 7-bit binary to two-digit BCD converter (shift-and-add-3).
// Results are meaningful for inputs 0..99; the hundreds digit is dropped.
module bin2bcd (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  logic [14:0] sr;

  always_comb begin
    sr = {8'd0, bin};
    for (int i = 0; i < 7; i++) begin
      if (sr[10:7] >= 4'd5) sr[10:7] = sr[10:7] + 4'd3;
      if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
      sr = sr << 1;
    end
    bcd = sr[14:7];
  end

endmodule

// File: rtl/edit_field_ctrl.sv
// Edit-mode controller for the clock overlay: cursor/value editing, button
// flash, and per-field BCD commit to the RTC. Optional: EDIT_CURSOR_BLINK_EN.
module edit_field_ctrl
  import edit_pkg::*;
#(
  parameter int FLASH_FRAMES = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_mode,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        ld_valid,
  input  logic [3:0]  ld_idx,
  input  logic [6:0]  ld_data,
  input  logic        wr_ack,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        edit_on,
  output logic [3:0]  cur_field,
  output logic        cursor_vis,
  output logic [3:0]  btn_flash,
  output logic [62:0] fields
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);

  state_t      state, state_next;
  logic [6:0]  field_q [NUM_FIELDS];
  logic [3:0]  commit_idx;
  logic [7:0]  commit_bcd;
  logic [6:0]  commit_val;
  logic [FW-1:0] flash_cnt [4];
  logic [3:0]  press;
  logic        ld_ok;
  logic        in_commit;

  assign in_commit = (state == COMMIT_REQ) || (state == COMMIT_WAIT);
  assign press     = {btn_down, btn_up, btn_right, btn_left} & {4{~in_commit}};
  assign ld_ok     = ld_valid && (ld_idx <= FLD_TSEC) &&
                     (ld_data >= FIELD_MIN[ld_idx]) && (ld_data <= FIELD_MAX[ld_idx]);
  assign commit_val = field_q[commit_idx];

  bin2bcd u_bin2bcd (
    .bin (commit_val),
    .bcd (commit_bcd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:        if (btn_mode) state_next = EDIT;
      EDIT:        if (btn_mode) state_next = COMMIT_REQ;
      COMMIT_REQ:  state_next = COMMIT_WAIT;
      COMMIT_WAIT: if (wr_ack && wr_req)
                     state_next = (commit_idx == FLD_TSEC) ? IDLE : COMMIT_REQ;
      default:     state_next = IDLE;
    endcase
  end

`ifdef EDIT_CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  // Held primed outside EDIT so the cursor starts visible on entry.
  always_ff @(posedge clk) begin
    if (rst || state != EDIT || btn_up || btn_down) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    edit_on   = (state == EDIT);
`ifdef EDIT_CURSOR_BLINK_EN
    cursor_vis = edit_on & blink_q;
`else
    cursor_vis = edit_on;
`endif
    btn_flash = '0;
    for (int k = 0; k < 4; k++) btn_flash[k] = (flash_cnt[k] != '0);
    fields = '0;
    for (int i = 0; i < NUM_FIELDS; i++) fields[i*7 +: 7] = field_q[i];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst)                              flash_cnt[k] <= '0;
      else if (press[k])                    flash_cnt[k] <= FW'(FLASH_FRAMES);
      else if (frame_tick && flash_cnt[k] != '0) flash_cnt[k] <= flash_cnt[k] - 1'b1;
    end
  end

  // NOTE: the field array is a handful of flops with defined power-up
  // contents, not a RAM, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FIELDS; i++) field_q[i] <= 7'd0;
      field_q[FLD_DAY]   <= 7'd1;
      field_q[FLD_MONTH] <= 7'd1;
      cur_field  <= FLD_DAY;
      commit_idx <= 4'd0;
      wr_req     <= 1'b0;
      wr_addr    <= 8'd0;
      wr_data    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_ok)    field_q[ld_idx] <= ld_data;
          if (btn_mode) cur_field <= FLD_DAY;
        end
        EDIT: begin
          // One action per cycle: mode > up > down > left > right.
          if (btn_mode)       commit_idx <= 4'd0;
          else if (btn_up)    field_q[cur_field] <= field_inc(cur_field, field_q[cur_field]);
          else if (btn_down)  field_q[cur_field] <= field_dec(cur_field, field_q[cur_field]);
          else if (btn_left)  cur_field <= (cur_field == FLD_DAY) ? FLD_TSEC : cur_field - 4'd1;
          else if (btn_right) cur_field <= (cur_field == FLD_TSEC) ? FLD_DAY : cur_field + 4'd1;
        end
        COMMIT_REQ: begin
          wr_req  <= 1'b1;
          wr_addr <= RTC_ADDR[commit_idx];
          wr_data <= commit_bcd;
        end
        COMMIT_WAIT: begin
          if (wr_ack && wr_req) begin
            wr_req <= 1'b0;
            if (commit_idx != FLD_TSEC) commit_idx <= commit_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/edit_field_ctrl.md
Name: edit_field_ctrl

Overview:
- Edit-mode controller for the clock overlay. Owns the nine displayed fields: date (day/month/year), time (hh/mm/ss) and timer (hh/mm/ss).
- Sequences cursor movement and value changes from the four instruction buttons (left/right/up/down) plus a mode button.
- Drives cursor and button-flash highlight signals to the overlay renderer.
- Commits edited values to the RTC bus interface through a req/ack handshake, one field per transaction, in BCD.

Parameters:
- FLASH_FRAMES, 8: number of frame_tick pulses a button-flash output stays high after a press.
- BLINK_FRAMES, 16: frame_ticks per cursor blink half-period; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- frame_tick  in  1  one-cycle pulse per video frame, at the start of vertical blank.
- btn_mode  in  1  one-cycle debounced pulse.
- btn_left, btn_right, btn_up, btn_down  in  1 each  one-cycle debounced pulses.
- ld_valid  in  1  load one field value from the RTC readback.
- ld_idx  in  4  field index 0..8 for the load.
- ld_data  in  7  binary field value for the load.
- wr_ack  in  1  RTC interface accepted the current write.
- wr_req  out  1  write request.
- wr_addr  out  8  RTC register address.
- wr_data  out  8  BCD field value.
- edit_on  out  1  high in EDIT state.
- cur_field  out  4  cursor position, 0..8.
- cursor_vis  out  1  cursor highlight enable.
- btn_flash  out  4  {down, up, right, left} highlight flags for the button boxes.
- fields  out  63  nine 7-bit binary values, field 0 in bits [6:0].

Behaviour:
- Reset is rst, synchronous, active-high.
- Reset values: state IDLE; wr_req 0; wr_addr 0; wr_data 0; edit_on 0; cur_field 0; cursor_vis 0; btn_flash 0; all fields 0 except day = 1 and month = 1.
- Field indices:
  - 0 day (1..31), 1 month (1..12), 2 year (0..99).
  - 3 hour (0..23), 4 min (0..59), 5 sec (0..59).
  - 6 timer hour (0..23), 7 timer min (0..59), 8 timer sec (0..59).
- RTC addresses by index: 0x24, 0x25, 0x26, 0x23, 0x22, 0x21, 0x43, 0x42, 0x41.
- FSM states: IDLE, EDIT, COMMIT_REQ, COMMIT_WAIT.
- IDLE:
  - ld_valid writes ld_data into field ld_idx on the next edge.
  - ld_idx > 8, or ld_data outside the field's range, is ignored.
  - btn_mode -> EDIT, with cur_field = 0.
  - Direction buttons are ignored, except for their flash.
- EDIT:
  - ld_valid is ignored.
  - btn_right: cur_field + 1, wrapping 8 -> 0. btn_left: cur_field - 1, wrapping 0 -> 8.
  - btn_up: field + 1, wrapping max -> min. btn_down: field - 1, wrapping min -> max.
  - Every update is visible on the outputs the cycle after the pulse.
  - btn_mode -> COMMIT_REQ with commit index 0.
- Simultaneous presses: only one action per cycle, priority mode > up > down > left > right. All pressed buttons still start their flash.
- COMMIT_REQ:
  - Drive wr_req = 1, wr_addr from the address table, wr_data = BCD of the field; go to COMMIT_WAIT.
  - wr_addr and wr_data stay stable while wr_req is high.
- COMMIT_WAIT:
  - On wr_ack: drop wr_req the next cycle. If index == 8 -> IDLE; else index + 1 -> COMMIT_REQ.
  - A transaction therefore takes at least 2 cycles; no timeout.
- During COMMIT states:
  - All buttons and ld_valid are ignored.
  - edit_on = 0.
  - cur_field holds the value it had when leaving EDIT.
- wr_ack while wr_req = 0 is ignored.
- btn_flash: each bit reloads a per-button counter with FLASH_FRAMES on a press and decrements on frame_tick. The bit is high while its counter is non-zero. A new press restarts the count.
- cursor_vis equals edit_on unless the optional feature is enabled.
- Reset mid-commit aborts the transaction. wr_req falls on the reset edge, with no partial-commit recovery.

Optional Feature:
- Macro EDIT_CURSOR_BLINK_EN.
- Defined: in EDIT, cursor_vis toggles every BLINK_FRAMES frame_ticks, starting high on entry to EDIT. Any up/down press forces it high and restarts the blink count. It is 0 outside EDIT.
- Undefined: cursor_vis = edit_on; no blink counter is synthesized.

Decomposition:
- Package edit_pkg holds:
  - the state enum;
  - field index constants;
  - per-field MIN/MAX tables;
  - the RTC address table;
  - NUM_FIELDS = 9.
- Sub-module bin2bcd (7-bit binary -> 8-bit BCD, combinational, valid for 0..99) generates wr_data.

Test Plan:
1. Reset, then mode pulse, then up ×3 -> edit_on = 1, cur_field = 0, day = 4; btn_flash[2] high for exactly 8 frame_ticks.
2. Left from cur_field 0 -> 8. Down on timer sec = 0 -> 59. Up on month = 12 -> 1.
3. Up and left asserted in the same cycle in EDIT -> only the field value increments, cur_field is unchanged, and both flash bits go high.
4. Mode in EDIT with hour = 23 and ack returned 3 cycles after each req -> nine writes in address order 0x24 … 0x41. The hour write is addr 0x23, data 0x23. wr_req drops after the last ack; state returns to IDLE.
5. IDLE: ld_valid idx 4 data 45 -> min = 45. ld_valid idx 4 data 60, or idx 9 -> fields unchanged. ld_valid during EDIT -> ignored.
6. rst asserted during COMMIT_WAIT of index 3 -> next cycle wr_req = 0, all outputs at reset values. A spurious wr_ack afterwards has no effect.
